// File: rtl/spi_arbiter.sv
// Round-robin owner arbitration for the shared SPI write path (data fifo, request queue, engine).
// An owner gets one start pulse per grant; the grant is dropped on done, timeout, or abort.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 50000,
  parameter int IDW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] release_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  owner_o,
  output logic            spi_start_o,
  input  logic            spi_busy_i,
  input  logic            spi_done_i,
  output logic [7:0]      status_o,
  output logic            busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h3A;
  localparam logic [7:0] ST_ABORT   = 8'h3B;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE, RELEASE} state_t;

  state_t            state, state_d;
  logic [IDW-1:0]    rr, rr_d, owner_d, sel;
  logic [NREQ-1:0]   grant_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [7:0]        status_d;
  logic              start_d, own_rel, own_req, tmo, hi_found, lo_found;
  logic [IDW-1:0]    hi_sel, lo_sel;

  // grant_o is one-hot on the owner while held, so masking avoids a variable index
  assign own_rel = |(release_i & grant_o);
  assign own_req = |(req_i & grant_o);
  assign tmo     = (cnt == CNT_LAST);
  assign busy_o  = (state != IDLE);

  // First requester at or after rr; otherwise the lowest one (wrap-around)
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_found = 1'b1;
        lo_sel   = IDW'(j);
        if (j >= int'(rr)) begin
          hi_found = 1'b1;
          hi_sel   = IDW'(j);
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_o     <= '0;
      owner_o     <= '0;
      spi_start_o <= 1'b0;
      status_o    <= ST_OK;
      rr          <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      grant_o     <= grant_d;
      owner_o     <= owner_d;
      spi_start_o <= start_d;
      status_o    <= status_d;
      rr          <= rr_d;
      cnt         <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (lo_found && !spi_busy_i) state_d = GRANT;
      GRANT:     if (tmo || !own_req) state_d = RELEASE;
                 else if (own_rel) state_d = WAIT_DONE;
      WAIT_DONE: if (spi_done_i || tmo) state_d = RELEASE;
      RELEASE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // release wins over a same-cycle request drop
    if (state == GRANT && !tmo && own_rel) state_d = WAIT_DONE;
  end

  always_comb begin
    grant_d  = grant_o;
    owner_d  = owner_o;
    start_d  = 1'b0;
    status_d = status_o;
    rr_d     = rr;
    cnt_d    = cnt;
    if ((state == GRANT || state == WAIT_DONE) && cnt != CNT_MAX) cnt_d = cnt + CW'(1);
    case (state)
      IDLE: if (lo_found && !spi_busy_i) begin
        grant_d = NREQ'(1) << sel;
        owner_d = sel;
        cnt_d   = '0;
      end
      GRANT: begin
        if (tmo) begin
          status_d = ST_TIMEOUT;
          grant_d  = '0;
        end else if (own_rel) begin
          start_d = 1'b1;
        end else if (!own_req) begin
          status_d = ST_ABORT;
          grant_d  = '0;
        end
      end
      WAIT_DONE: begin
        if (spi_done_i) begin
          status_d = ST_OK;
          grant_d  = '0;
        end else if (tmo) begin
          status_d = ST_TIMEOUT;
          grant_d  = '0;
        end
      end
      RELEASE: rr_d = (int'(owner_o) == NREQ - 1) ? '0 : owner_o + IDW'(1);
      default: grant_d = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: fairness, single transfer, timeout, abort, busy gating, async reset.
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i, release_i, grant_o;
  logic [1:0] owner_o;
  logic       spi_start_o, spi_busy_i, spi_done_i, busy_o;
  logic [7:0] status_o;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int s0;
  logic [3:0] e;
  int seq[5] = '{0, 1, 2, 3, 0};

  spi_arbiter #(.NREQ(4), .TIMEOUT(100), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .release_i(release_i), .grant_o(grant_o),
    .owner_o(owner_o), .spi_start_o(spi_start_o), .spi_busy_i(spi_busy_i),
    .spi_done_i(spi_done_i), .status_o(status_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (spi_start_o === 1'b1) starts++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; req_i = '0; release_i = '0; spi_busy_i = 1'b0; spi_done_i = 1'b0;
    #1;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_owner", 32'(owner_o), 0);
    chk("rst_start", 32'(spi_start_o), 0);
    chk("rst_status", 32'(status_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    tick(2);
    rst = 1'b1;

    // fairness: all requesting, order 0,1,2,3,0
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = 4'b0001 << seq[i];
      chk("rr_grant", 32'(grant_o), 32'(e));
      chk("rr_owner", 32'(owner_o), 32'(seq[i]));
      release_i = e;
      tick();
      release_i = '0;
      chk("rr_start", 32'(spi_start_o), 1);
      spi_done_i = 1'b1;
      tick();
      spi_done_i = 1'b0;
      chk("rr_drop", 32'(grant_o), 0);
      tick();
      chk("rr_gap", 32'(grant_o), 0);
    end
    req_i = '0;
    chk("rr_starts", 32'(starts), 5);

    // single request, done 20 clocks after start (rr now 1)
    tick();
    req_i = 4'b0010;
    tick();
    chk("one_grant", 32'(grant_o), 32'h2);
    chk("one_busy", 32'(busy_o), 1);
    s0 = starts;
    tick();
    release_i = 4'b0010;
    tick();
    release_i = '0;
    chk("one_start", 32'(spi_start_o), 1);
    chk("one_hold", 32'(grant_o), 32'h2);
    tick();
    chk("one_start_off", 32'(spi_start_o), 0);
    tick(18);
    spi_done_i = 1'b1;
    tick();
    spi_done_i = 1'b0;
    req_i = '0;
    chk("one_drop", 32'(grant_o), 0);
    chk("one_status", 32'(status_o), 32'h00);
    tick();
    chk("one_idle", 32'(busy_o), 0);
    chk("one_nstart", 32'(starts - s0), 1);

    // timeout: requester 2 holds without release (rr now 2)
    req_i = 4'b1100;
    tick();
    chk("to_grant", 32'(grant_o), 32'h4);
    s0 = starts;
    tick(99);
    chk("to_held", 32'(grant_o), 32'h4);
    tick();
    chk("to_drop", 32'(grant_o), 0);
    chk("to_status", 32'(status_o), 32'h3A);
    chk("to_nostart", 32'(starts - s0), 0);
    tick(2);
    chk("to_next", 32'(grant_o), 32'h8);
    chk("to_next_owner", 32'(owner_o), 3);
    release_i = 4'b1000;
    tick();
    release_i = '0;
    spi_done_i = 1'b1;
    tick();
    spi_done_i = 1'b0;
    req_i = '0;
    chk("to_recover", 32'(status_o), 32'h00);
    tick();

    // abort: owner 0 drops its request (rr now 0)
    req_i = 4'b0001;
    tick();
    chk("ab_grant", 32'(grant_o), 32'h1);
    s0 = starts;
    req_i = '0;
    tick();
    chk("ab_drop", 32'(grant_o), 0);
    chk("ab_status", 32'(status_o), 32'h3B);
    tick();
    chk("ab_nostart", 32'(starts - s0), 0);

    // release and request drop together: release wins (rr now 1)
    req_i = 4'b0010;
    tick();
    chk("rw_grant", 32'(grant_o), 32'h2);
    release_i = 4'b0010;
    req_i = '0;
    tick();
    release_i = '0;
    chk("rw_start", 32'(spi_start_o), 1);
    chk("rw_hold", 32'(grant_o), 32'h2);
    spi_done_i = 1'b1;
    tick();
    spi_done_i = 1'b0;
    chk("rw_status", 32'(status_o), 32'h00);
    tick();

    // busy gating (rr now 2, requester 0 wraps)
    spi_busy_i = 1'b1;
    req_i = 4'b0001;
    tick(3);
    chk("bz_nogrant", 32'(grant_o), 0);
    chk("bz_idle", 32'(busy_o), 0);
    spi_busy_i = 1'b0;
    tick();
    chk("bz_grant", 32'(grant_o), 32'h1);
    release_i = 4'b0001;
    tick();
    release_i = '0;
    spi_done_i = 1'b1;
    tick();
    spi_done_i = 1'b0;
    req_i = '0;
    tick();

    // async reset while requester 2 waits for done (rr now 1)
    req_i = 4'b0100;
    tick();
    release_i = 4'b0100;
    tick();
    release_i = '0;
    tick();
    chk("ar_pre", 32'(grant_o), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_grant", 32'(grant_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_owner", 32'(owner_o), 0);
    chk("ar_status", 32'(status_o), 0);
    chk("ar_start", 32'(spi_start_o), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_regrant", 32'(grant_o), 32'h4);
    chk("ar_reowner", 32'(owner_o), 2);
    req_i = '0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI write path (data fifo, write-request queue, SPI engine) among up to NREQ requester modules: bias, DDS, pulse and others.
- Grants exclusive ownership round-robin.
- Once the owner signals its data and queue entry are written, issues one start pulse to the SPI engine, waits for completion, then releases ownership.
- Sits in the top level between the opcode-driven requester modules and the SPI engine.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 50000, max clocks a grant may be held (GRANT + WAIT_DONE combined) before forced release
IDW, 2, owner index width (ceil log2 NREQ)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_i  in  NREQ  per-requester access request; held high until granted and released
release_i  in  NREQ  one-cycle pulse from the owner: SPI data and queue entry fully written
grant_o  out  NREQ  one-hot grant, registered
owner_o  out  IDW  index of current/last owner
spi_start_o  out  1  one-cycle start pulse to SPI engine
spi_busy_i  in  1  SPI engine busy
spi_done_i  in  1  one-cycle completion pulse from SPI engine
status_o  out  8  8'h00 SUCCESS; 8'h3A ERR_SPI_ARB_TIMEOUT; 8'h3B ERR_SPI_ARB_ABORT (both codes added to status.h)
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, grant_o=0, owner_o=0, spi_start_o=0, status_o=8'h00, busy_o=0, rr pointer=0, timeout counter=0. Reset mid-transaction drops the grant immediately and issues no start.
- States: IDLE, GRANT, WAIT_DONE, RELEASE.
- IDLE:
  - If any req_i is high and spi_busy_i=0, select the first requester at or after the rr pointer, wrapping modulo NREQ.
  - Next edge: grant_o[sel]=1, owner_o=sel, counter=0, go GRANT. Grant latency from req edge is one clock.
  - If spi_busy_i=1, hold in IDLE with no grant.
- GRANT:
  - counter increments every clock.
  - release_i[owner]=1: spi_start_o=1 for exactly one clock, go WAIT_DONE. grant_o stays high.
  - req_i[owner] falls without release: status_o=8'h3B, grant_o=0, no start, go RELEASE.
  - release_i[owner] and req_i[owner] fall in the same cycle: release wins, start is issued.
  - release_i from a non-owner is ignored.
- WAIT_DONE:
  - spi_done_i=1: status_o=8'h00, grant_o=0, go RELEASE.
  - spi_done_i in any other state is ignored.
- Timeout: counter reaching TIMEOUT-1 in GRANT or WAIT_DONE sets status_o=8'h3A, grant_o=0, go RELEASE. A spi_done_i arriving in that same cycle takes priority and gives SUCCESS.
- RELEASE:
  - rr pointer = owner+1, wrapping modulo NREQ; go IDLE.
  - One-clock gap is guaranteed between consecutive grants.
- status_o holds its value until the next transaction completes.
- Counter is wide enough for TIMEOUT; it saturates and never wraps.
- At most one grant_o bit is high at any time.
- spi_start_o never fires twice per grant.

Test Plan:
- Single request: req_i=4'b0010 → grant_o=4'b0010 one clock later. release_i[1] pulse → spi_start_o high exactly 1 clock. spi_done_i 20 clocks later → grant_o=0, status_o=8'h00, busy_o=0 two clocks after done.
- Fairness: req_i=4'b1111 held, each owner releases and gets done. Grant order must be 0,1,2,3,0; one idle clock between grants.
- Timeout: TIMEOUT=100, req_i[2] granted, no release → grant dropped after 100 clocks, status_o=8'h3A, no spi_start_o, next grant goes to requester 3.
- Abort: owner 0 drops req_i with no release → status_o=8'h3B, grant_o=0, no spi_start_o. Same-cycle release and req drop → start issued, status ends 8'h00.
- Busy gating: spi_busy_i=1 with req_i=4'b0001 → no grant. spi_busy_i falls → grant one clock later.
- Async reset: assert rst low in WAIT_DONE with grant_o=4'b0100 → all outputs zero without a clock edge. After reset release, req_i=4'b0100 is granted normally.
